// File: rtl/axis_to_uart_tx.sv
// AXI-stream to UART transmitter: FIFO-buffered bytes leave as framed serial data under CTS flow control.
// Define UART_TX_PARITY_EN to insert a parity bit after the data bits (sense set by PARITY_ODD).
module axis_to_uart_tx #(
    parameter real CLOCK_FREQ = 133000000.0,
    parameter real BAUD_RATE  = 115200.0,
    parameter int  DATA_BITS  = 8,
    parameter int  STOP_BITS  = 1,
    parameter int  FIFO_AW    = 4,
    parameter bit  PARITY_ODD = 1'b0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] idata,
    input  logic                 ivalid,
    output logic                 iready,
    output logic                 txd_pin,
    input  logic                 ctsn_pin,
    output logic                 busy,
    output logic [FIFO_AW:0]     level
);

    localparam int BAUD_RAW   = $rtoi(CLOCK_FREQ / BAUD_RATE + 0.5);
    localparam int BAUD_COUNT = (BAUD_RAW < 2) ? 2 : BAUD_RAW;
    localparam int BAUD_W     = $clog2(BAUD_COUNT);
    localparam int DEPTH      = 2 ** FIFO_AW;

    localparam logic [BAUD_W-1:0]  BAUD_LOAD = BAUD_W'(BAUD_COUNT - 1);
    localparam logic [BAUD_W-1:0]  BAUD_ONE  = BAUD_W'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [3:0]         LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0]         LAST_STOP = 4'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    // Clear-to-send synchronizer; resets to the deasserted level.
    logic cts_meta_reg;
    logic cts_sync_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cts_meta_reg <= 1'b1;
            cts_sync_reg <= 1'b1;
        end else begin
            cts_meta_reg <= ctsn_pin;
            cts_sync_reg <= cts_meta_reg;
        end
    end

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] rd_data_reg;
    logic [FIFO_AW-1:0]   wr_ptr_reg;
    logic [FIFO_AW-1:0]   rd_ptr_reg;
    logic [FIFO_AW:0]     count_reg;
    logic [FIFO_AW:0]     count_next;
    logic                 iready_reg;
    logic                 push;
    logic                 pop;
    logic                 fifo_empty;

    assign push       = ivalid & iready_reg;
    assign fifo_empty = (count_reg == '0);

    always_comb begin
        count_next = count_reg;
        if (push && !pop) begin
            count_next = count_reg + CNT_ONE;
        end else if (pop && !push) begin
            count_next = count_reg - CNT_ONE;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            iready_reg <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
            count_reg  <= count_next;
            iready_reg <= (count_next != CNT_FULL);
        end
    end

    // Storage and registered read port; the popped word is ready long before the first data bit.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr_reg] <= idata;
        end
        if (pop) begin
            rd_data_reg <= mem[rd_ptr_reg];
        end
    end

    state_t               state_reg;
    state_t               state_next;
    logic [BAUD_W-1:0]    baud_cnt_reg;
    logic [BAUD_W-1:0]    baud_cnt_next;
    logic [3:0]           bit_cnt_reg;
    logic [3:0]           bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic                 txd_reg;
    logic                 txd_next;
    logic                 busy_reg;
    logic                 busy_next;
    logic                 start_ok;
    logic                 bit_end;
`ifdef UART_TX_PARITY_EN
    logic                 parity_reg;
    logic                 parity_next;
`else
    logic                 unused_parity_cfg;
    assign unused_parity_cfg = PARITY_ODD;
`endif

    assign start_ok = !fifo_empty && !cts_sync_reg;
    assign bit_end  = (baud_cnt_reg == '0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            baud_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            txd_reg      <= 1'b1;
            busy_reg     <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= 1'b0;
`endif
        end else begin
            state_reg    <= state_next;
            baud_cnt_reg <= baud_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            txd_reg      <= txd_next;
            busy_reg     <= busy_next;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= parity_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        baud_cnt_next = baud_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        pop           = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_next   = parity_reg;
`endif
        // The baud counter only moves inside a frame; each bit reloads it.
        if (state_reg != IDLE && !bit_end) begin
            baud_cnt_next = baud_cnt_reg - BAUD_ONE;
        end

        case (state_reg)
            IDLE: begin
                if (start_ok) begin
                    state_next    = START;
                    pop           = 1'b1;
                    baud_cnt_next = BAUD_LOAD;
                end
            end
            START: begin
                if (bit_end) begin
                    state_next    = DATA;
                    shift_next    = rd_data_reg;
                    bit_cnt_next  = '0;
                    baud_cnt_next = BAUD_LOAD;
`ifdef UART_TX_PARITY_EN
                    parity_next   = (^rd_data_reg) ^ PARITY_ODD;
`endif
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_next = BAUD_LOAD;
                    shift_next    = {1'b0, shift_reg[DATA_BITS-1:1]};
                    if (bit_cnt_reg == LAST_DATA) begin
                        bit_cnt_next = '0;
`ifdef UART_TX_PARITY_EN
                        state_next   = PARITY;
`else
                        state_next   = STOP;
`endif
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 4'd1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_next    = STOP;
                    bit_cnt_next  = '0;
                    baud_cnt_next = BAUD_LOAD;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (bit_cnt_reg == LAST_STOP) begin
                        // Chain straight into the next start bit when data and CTS allow.
                        if (start_ok) begin
                            state_next    = START;
                            pop           = 1'b1;
                            baud_cnt_next = BAUD_LOAD;
                        end else begin
                            state_next    = IDLE;
                        end
                    end else begin
                        bit_cnt_next  = bit_cnt_reg + 4'd1;
                        baud_cnt_next = BAUD_LOAD;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
        case (state_next)
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  txd_next = parity_next;
`endif
            default: txd_next = 1'b1;
        endcase
    end

    assign iready  = iready_reg;
    assign txd_pin = txd_reg;
    assign busy    = busy_reg;
    assign level   = count_reg;

endmodule

// File: tb/tb_axis_to_uart_tx.sv
// Self-checking bench for axis_to_uart_tx: 16 clocks per bit, 4-entry FIFO, frames decoded against a scoreboard.
`timescale 1ns/1ps
module tb_axis_to_uart_tx;

    localparam int  DATA_BITS  = 8;
    localparam int  STOP_BITS  = 1;
    localparam int  FIFO_AW    = 2;
    localparam bit  PARITY_ODD = 1'b0;
    localparam int  BAUD_CLKS  = 16;
`ifdef UART_TX_PARITY_EN
    localparam int  PAR_BITS   = 1;
`else
    localparam int  PAR_BITS   = 0;
`endif
    localparam int  FRAME_BITS = 1 + DATA_BITS + PAR_BITS + STOP_BITS;
    localparam int  FRAME_CLKS = FRAME_BITS * BAUD_CLKS;

    logic                 clock = 1'b0;
    logic                 reset;
    logic [DATA_BITS-1:0] idata;
    logic                 ivalid;
    logic                 iready;
    logic                 txd_pin;
    logic                 ctsn_pin;
    logic                 busy;
    logic [FIFO_AW:0]     level;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;
    int frame_cnt = 0;
    bit in_frame = 1'b0;
    logic [DATA_BITS-1:0] sb [$];
    int frame_starts [$];

    axis_to_uart_tx #(
        .CLOCK_FREQ (1.6e6),
        .BAUD_RATE  (1.0e5),
        .DATA_BITS  (DATA_BITS),
        .STOP_BITS  (STOP_BITS),
        .FIFO_AW    (FIFO_AW),
        .PARITY_ODD (PARITY_ODD)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .idata    (idata),
        .ivalid   (ivalid),
        .iready   (iready),
        .txd_pin  (txd_pin),
        .ctsn_pin (ctsn_pin),
        .busy     (busy),
        .level    (level)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cycle <= cycle + 1;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [DATA_BITS-1:0] d);
        logic [FRAME_BITS-1:0] f;
        f    = '1;
        f[0] = 1'b0;
        for (int i = 0; i < DATA_BITS; i++) f[1+i] = d[i];
`ifdef UART_TX_PARITY_EN
        f[1+DATA_BITS] = (^d) ^ PARITY_ODD;
`endif
        return f;
    endfunction

    // Frame monitor: pops the expected byte at each start bit and checks every clock of the frame.
    initial begin : monitor
        logic                  prev_txd;
        logic [DATA_BITS-1:0]  exp_byte;
        logic [DATA_BITS-1:0]  got;
        logic [FRAME_BITS-1:0] exp_bits;
        logic [FRAME_BITS-1:0] bad;
        logic [FRAME_BITS-1:0] bad_val;
        bit                    aborted;
        bit                    busy_bad;
        int                    bi;
        prev_txd = 1'b1;
        forever begin
            @(negedge clock);
            if (reset !== 1'b1 && prev_txd === 1'b1 && txd_pin === 1'b0) begin
                in_frame = 1'b1;
                frame_starts.push_back(cycle);
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cycle);
                    exp_byte = '0;
                end else begin
                    exp_byte = sb.pop_front();
                end
                exp_bits = build_frame(exp_byte);
                bad      = '0;
                bad_val  = '0;
                got      = '0;
                aborted  = 1'b0;
                busy_bad = 1'b0;
                for (int i = 0; i < FRAME_CLKS; i++) begin
                    if (i > 0) @(negedge clock);
                    if (reset === 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    bi = i / BAUD_CLKS;
                    if (txd_pin !== exp_bits[bi] && !bad[bi]) begin
                        bad[bi]     = 1'b1;
                        bad_val[bi] = txd_pin;
                    end
                    if (busy !== 1'b1) busy_bad = 1'b1;
                    if ((i % BAUD_CLKS) == BAUD_CLKS / 2 && bi >= 1 && bi <= DATA_BITS)
                        got[bi-1] = txd_pin;
                end
                if (!aborted) begin
                    for (int b = 0; b < FRAME_BITS; b++) begin
                        n_checks++;
                        if (bad[b]) begin
                            n_fail++;
                            $display("FAIL frame_bit%0d: byte 0x%02h txd %b, required %b for %0d clocks",
                                     b, exp_byte, bad_val[b], exp_bits[b], BAUD_CLKS);
                        end
                    end
                    n_checks++;
                    if (got !== exp_byte) begin
                        n_fail++;
                        $display("FAIL frame_data: received 0x%02h, required 0x%02h", got, exp_byte);
                    end
                    n_checks++;
                    if (busy_bad) begin
                        n_fail++;
                        $display("FAIL frame_busy: busy low inside frame of 0x%02h, required high", exp_byte);
                    end
                    frame_cnt++;
                    $display("frame %0d: received 0x%02h expected 0x%02h", frame_cnt, got, exp_byte);
                    prev_txd = 1'b1;
                end else begin
                    $display("frame aborted by reset: expected 0x%02h", exp_byte);
                    prev_txd = txd_pin;
                end
                in_frame = 1'b0;
            end else begin
                prev_txd = txd_pin;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic push_word(input logic [DATA_BITS-1:0] d, output bit accepted);
        @(negedge clock);
        idata    = d;
        ivalid   = 1'b1;
        accepted = (iready === 1'b1);
        if (accepted) sb.push_back(d);
        @(posedge clock);
        #1;
        ivalid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || busy !== 1'b0 || in_frame || level !== '0) && n < 4000) begin
            @(negedge clock);
            n++;
        end
        n_checks++;
        if (n >= 4000) begin
            n_fail++;
            $display("FAIL %s_timeout: not idle after %0d cycles, required idle", tag, n);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ivalid   = 1'b0;
        idata    = '0;
        ctsn_pin = 1'b0;
        repeat (3) @(negedge clock);
        n_checks++;
        if (txd_pin !== 1'b1 || iready !== 1'b0 || busy !== 1'b0 || level !== '0) begin
            n_fail++;
            $display("FAIL reset_state: txd=%b iready=%b busy=%b level=%0d, required 1 0 0 0",
                     txd_pin, iready, busy, level);
        end
        reset = 1'b0;
        #1;
        n_checks++;
        if (iready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_iready: iready=%b before first edge, required 0", iready);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (iready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_first_edge_iready: iready=%b, required 1", iready);
        end
        repeat (3) @(negedge clock);
    endtask

    task automatic test_single_frame();
        bit acc;
        int hi;
        push_word(8'h55, acc);
        n_checks++;
        if (!acc || level !== 3'd1 || txd_pin !== 1'b1) begin
            n_fail++;
            $display("FAIL latency_accept: acc=%b level=%0d txd=%b after accept edge, required 1 1 1",
                     acc, level, txd_pin);
        end
        @(posedge clock);
        #1;
        n_checks++;
        if (txd_pin !== 1'b0 || busy !== 1'b1 || level !== 3'd0) begin
            n_fail++;
            $display("FAIL latency_start: txd=%b busy=%b level=%0d one edge later, required 0 1 0",
                     txd_pin, busy, level);
        end
        hi = 1;
        while (busy === 1'b1 && hi < 1000) begin
            @(posedge clock);
            #1;
            if (busy === 1'b1) hi++;
        end
        n_checks++;
        if (hi != FRAME_CLKS) begin
            n_fail++;
            $display("FAIL busy_length: busy high %0d clocks, required %0d", hi, FRAME_CLKS);
        end
        wait_idle("single");
    endtask

    task automatic test_patterns();
        logic [DATA_BITS-1:0] pats [6] = '{8'hA3, 8'h00, 8'hFF, 8'h07, 8'h80, 8'h3C};
        bit acc;
        int tries;
        for (int p = 0; p < 6; p++) begin
            acc   = 1'b0;
            tries = 0;
            while (!acc && tries < 1000) begin
                push_word(pats[p], acc);
                tries++;
            end
            n_checks++;
            if (!acc) begin
                n_fail++;
                $display("FAIL pattern_accept: 0x%02h not accepted, required accepted", pats[p]);
            end
        end
        wait_idle("patterns");
    endtask

    task automatic test_fifo_full();
        logic [DATA_BITS-1:0] words [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        bit acc;
        int n_acc;
        bit txd_moved;
        ctsn_pin = 1'b1;
        repeat (4) @(negedge clock);
        n_acc = 0;
        for (int w = 0; w < 5; w++) begin
            push_word(words[w], acc);
            if (acc) n_acc++;
        end
        n_checks++;
        if (n_acc != 4) begin
            n_fail++;
            $display("FAIL full_accept_count: accepted %0d, required 4", n_acc);
        end
        n_checks++;
        if (level !== 3'd4 || iready !== 1'b0) begin
            n_fail++;
            $display("FAIL full_flags: level=%0d iready=%b, required 4 0", level, iready);
        end
        txd_moved = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (txd_pin !== 1'b1 || busy !== 1'b0) txd_moved = 1'b1;
        end
        n_checks++;
        if (txd_moved) begin
            n_fail++;
            $display("FAIL cts_hold: line active with CTS deasserted, required txd=1 busy=0");
        end
        frame_starts.delete();
        ctsn_pin = 1'b0;
        wait_idle("full_drain");
        n_checks++;
        if (frame_starts.size() != 4) begin
            n_fail++;
            $display("FAIL drain_frames: %0d frames, required 4", frame_starts.size());
        end else begin
            for (int g = 1; g < 4; g++) begin
                n_checks++;
                if (frame_starts[g] - frame_starts[g-1] != FRAME_CLKS) begin
                    n_fail++;
                    $display("FAIL back_to_back_gap%0d: start spacing %0d clocks, required %0d",
                             g, frame_starts[g] - frame_starts[g-1], FRAME_CLKS);
                end
            end
        end
    endtask

    task automatic test_cts_midframe();
        bit acc;
        bit line_active;
        int n;
        push_word(8'hA3, acc);
        push_word(8'h5A, acc);
        repeat (50) @(negedge clock);
        ctsn_pin = 1'b1;
        n = 0;
        while (busy === 1'b1 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        line_active = 1'b0;
        repeat (40) begin
            @(negedge clock);
            if (txd_pin !== 1'b1 || busy !== 1'b0) line_active = 1'b1;
        end
        n_checks++;
        if (line_active || level !== 3'd1) begin
            n_fail++;
            $display("FAIL cts_pause: active=%b level=%0d after frame with CTS high, required 0 1",
                     line_active, level);
        end
        @(negedge clock);
        ctsn_pin = 1'b0;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (txd_pin !== 1'b0 && n < 10);
        n_checks++;
        if (n < 2 || n > 3) begin
            n_fail++;
            $display("FAIL cts_resume_latency: start after %0d edges, required 2..3", n);
        end
        wait_idle("cts");
    endtask

    task automatic test_reset_midframe();
        logic [DATA_BITS-1:0] words [4] = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        bit acc;
        bit line_active;
        for (int w = 0; w < 4; w++) push_word(words[w], acc);
        n_checks++;
        if (level !== 3'd3 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_level: level=%0d busy=%b, required 3 1", level, busy);
        end
        repeat (40) @(negedge clock);
        @(negedge clock);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (txd_pin !== 1'b1 || level !== '0 || busy !== 1'b0 || iready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midframe: txd=%b level=%0d busy=%b iready=%b, required 1 0 0 0",
                     txd_pin, level, busy, iready);
        end
        sb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        n_checks++;
        if (iready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_midframe_release: iready=%b one edge after release, required 1", iready);
        end
        line_active = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (txd_pin !== 1'b1 || level !== '0) line_active = 1'b1;
        end
        n_checks++;
        if (line_active) begin
            n_fail++;
            $display("FAIL reset_discard: line or FIFO active after reset, required idle and empty");
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_patterns();
        test_fifo_full();
        test_cts_midframe();
        test_reset_midframe();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_left: %0d words never sent, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
